uart_frame_parser: RTL



---
 rtl/uart_frame_parser.sv | 66 ++++++
 1 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: finds a two-byte header, collects a fixed-length payload, and aborts a frame if the next byte is too late
module uart_frame_parser #(
  parameter int PAYLOAD_LEN = 6,
  parameter logic [7:0] HEAD0 = 8'hEF,
  parameter logic [7:0] HEAD1 = 8'hFA,
  parameter int TIMEOUT_CYC = 156240
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [7:0]               ser_to_para,
  input  logic                     flag_end,
  output logic [8*PAYLOAD_LEN-1:0] frame_data,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy
);
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam int CW = $clog2(PAYLOAD_LEN) + 1;
  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tmo;
  logic [8*PAYLOAD_LEN-1:0] acc, acc_nxt;
  logic last, timeout;
  // decode next state, buffer write, end of frame and timeout; an arriving byte takes priority over the timeout
  always_comb begin
    acc_nxt = acc;
    if (state == PAYLOAD && flag_end) acc_nxt[8*int'(cnt) +: 8] = ser_to_para;
    last = flag_end && state == PAYLOAD && cnt == CW'(PAYLOAD_LEN - 1);
    timeout = state != IDLE && !flag_end && tmo == TW'(TIMEOUT_CYC - 1);
    state_nxt = timeout ? IDLE : !flag_end ? state :
                state == IDLE ? (ser_to_para == HEAD0 ? HDR1 : IDLE) :
                state == HDR1 ? (ser_to_para == HEAD1 ? PAYLOAD : ser_to_para == HEAD0 ? HDR1 : IDLE) :
                last ? IDLE : PAYLOAD;
  end
  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else state <= state_nxt;
  end
  // payload byte index, inter-byte timer and assembly buffer
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt <= '0;
      tmo <= '0;
      acc <= '0;
    end else begin
      cnt <= (state != PAYLOAD || state_nxt != PAYLOAD) ? '0 : flag_end ? cnt + CW'(1) : cnt;
      tmo <= (state == IDLE || flag_end || timeout) ? '0 : tmo + TW'(1);
      acc <= acc_nxt;
    end
  end
  // frame_data changes only when a frame completes; the strobes last one cycle
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_data  <= last ? acc_nxt : frame_data;
      frame_valid <= last;
      frame_err   <= timeout;
    end
  end
  assign busy = state != IDLE;
endmodule
